// File: rtl/wb_write_buffer.sv
// rtl/wb_write_buffer.sv - in-order register write-back queue with forwarding lookup
module wb_write_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 5
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [ADDR_W-1:0]          in_addr,
  input  logic [31:0]                in_data,
  input  logic                       wr_stall,
  output logic                       wr_en,
  output logic [ADDR_W-1:0]          wr_addr,
  output logic [31:0]                wr_data,
  input  logic [ADDR_W-1:0]          fwd_addr,
  output logic                       fwd_hit,
  output logic [31:0]                fwd_data,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [31:0]       data_q [DEPTH];
  logic [PTR_W-1:0]  head_q, tail_q;
  logic [CNT_W-1:0]  count_q, count_d;
  // Value presented on the write port once the queue runs empty.
  logic [ADDR_W-1:0] last_addr_q;
  logic [31:0]       last_data_q;
  logic              push, pop;
  logic [PTR_W-1:0]  fwd_idx;

  assign in_ready = (count_q < CNT_W'(DEPTH));
  assign wr_en    = (count_q != '0) && !wr_stall;
  assign pop      = wr_en;
  // Address 0 is hardwired zero: the beat is consumed but never stored.
  assign push     = in_valid && in_ready && (in_addr != '0);
  assign wr_addr  = (count_q != '0) ? addr_q[head_q] : last_addr_q;
  assign wr_data  = (count_q != '0) ? data_q[head_q] : last_data_q;
  assign count    = count_q;

  // Occupancy follows push/pop; simultaneous push and pop cancel out.
  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Scan oldest to youngest so the youngest matching entry is the one left standing.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    fwd_idx  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      fwd_idx = head_q + PTR_W'(i);
      if ((CNT_W'(i) < count_q) && (fwd_addr != '0) && (addr_q[fwd_idx] == fwd_addr)) begin
        fwd_hit  = 1'b1;
        fwd_data = data_q[fwd_idx];
      end
    end
  end

  // Pointers, occupancy, storage and last-written value; reset discards everything pending.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      last_addr_q <= '0;
      last_data_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      count_q <= count_d;
      if (push) begin
        addr_q[tail_q] <= in_addr;
        data_q[tail_q] <= in_data;
        tail_q         <= tail_q + PTR_W'(1);
      end
      if (pop) begin
        last_addr_q <= addr_q[head_q];
        last_data_q <= data_q[head_q];
        head_q      <= head_q + PTR_W'(1);
      end
    end
  end

endmodule
